// File: rtl/read_controller.sv
// Read-response serialiser: turns one {address, data} register read into a
// UART_PACKET byte stream. Optional trailing XOR checksum byte under READ_CHECKSUM_EN.
package uart_pkg;
    typedef struct packed {
        logic       Valid;
        logic       SoP;
        logic       EoP;
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
    } UART_PACKET;
endpackage

module read_controller
    import uart_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 4,
    parameter logic [7:0]  SOURCE_ID   = 8'h01
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic        ipRdValid,
    input  logic [7:0]  ipRdAddress,
    input  logic [31:0] ipRdData,
    output logic        opRdReady,
    input  logic        ipTxReady,
    output UART_PACKET  opTxStream
);

    if (DATA_LENGTH < 1 || DATA_LENGTH > 4) begin : g_bad_length
        $error("read_controller: DATA_LENGTH must be in 1..4");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ADDRESS  = 2'd1,
        DATA     = 2'd2
`ifdef READ_CHECKSUM_EN
        ,
        CHECKSUM = 2'd3
`endif
    } state_t;

    state_t      state, state_n;
    logic [1:0]  count, count_n;
    logic [7:0]  addr_q, addr_n;
    logic [31:0] data_q, data_n;
    logic        ready_n;
    UART_PACKET  tx_n;
    logic        transfer;

`ifdef READ_CHECKSUM_EN
    logic [7:0]  checksum;

    always_comb begin
        checksum = addr_q;
        for (int unsigned i = 0; i < DATA_LENGTH; i++) begin
            checksum = checksum ^ data_q[8*i +: 8];
        end
    end
`endif

    assign transfer = opTxStream.Valid && ipTxReady;

    always_comb begin
        state_n = state;
        count_n = count;
        addr_n  = addr_q;
        data_n  = data_q;

        case (state)
            IDLE: begin
                if (ipRdValid && opRdReady) begin
                    addr_n  = ipRdAddress;
                    data_n  = ipRdData;
                    state_n = ADDRESS;
                end
            end
            ADDRESS: begin
                if (transfer) begin
                    state_n = DATA;
                    count_n = 2'(DATA_LENGTH - 1);
                end
            end
            DATA: begin
                if (transfer) begin
                    if (count != 2'd0) begin
                        count_n = count - 2'd1;
                    end else begin
`ifdef READ_CHECKSUM_EN
                        state_n = CHECKSUM;
`else
                        state_n = IDLE;
`endif
                    end
                end
            end
`ifdef READ_CHECKSUM_EN
            CHECKSUM: begin
                if (transfer) begin
                    state_n = IDLE;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so every field is glitch-free
    // and naturally holds while stalled (state_n == state).
    always_comb begin
        ready_n = (state_n == IDLE);
        tx_n    = '0;
        case (state_n)
            ADDRESS: begin
                tx_n.Valid  = 1'b1;
                tx_n.SoP    = 1'b1;
                tx_n.Source = SOURCE_ID;
                tx_n.Data   = addr_n;
            end
            DATA: begin
                tx_n.Valid  = 1'b1;
                tx_n.Source = SOURCE_ID;
                tx_n.Data   = data_n[8*count_n +: 8];
`ifdef READ_CHECKSUM_EN
                tx_n.EoP    = 1'b0;
`else
                tx_n.EoP    = (count_n == 2'd0);
`endif
            end
`ifdef READ_CHECKSUM_EN
            CHECKSUM: begin
                tx_n.Valid  = 1'b1;
                tx_n.EoP    = 1'b1;
                tx_n.Source = SOURCE_ID;
                tx_n.Data   = checksum;
            end
`endif
            default: begin
                tx_n = '0;
            end
        endcase
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state      <= IDLE;
            count      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            opRdReady  <= 1'b0;
            opTxStream <= '0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            addr_q     <= addr_n;
            data_q     <= data_n;
            opRdReady  <= ready_n;
            opTxStream <= tx_n;
        end
    end

endmodule
